vga_timing_pipe: RTL and testbench

Parametrised VGA timing generator and pixel-alignment pipeline. It supersedes the fixed 640x480 controller in the camera-to-VGA path. It runs on the 25.175 MHz `vgaclk` and issues pixel requests (x, y) to an upstream source such as a camera frame buffer or a pattern ROM, with a configurable fixed read latency. It delays sync and blanking by the matching number of cycles so colour and sync reach the video DAC aligned. A built-in colour-bar generator can replace the upstream source, switching only on frame boundaries.

---
 rtl/vga_timing_pipe.sv | 149 ++++++++++++++
 tb/tb_vga_timing_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_pipe.sv
// VGA timing generator with a LAT-deep alignment pipeline, so that sync, blank
// and upstream colour reach the DAC together. Optional colour bars switch only per frame.
module vga_timing_pipe #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int LAT      = 2,
  parameter int CW       = 8
) (
  input  logic          vgaclk,
  input  logic          reset,
  input  logic          pattern_en,
  output logic          req_valid,
  output logic [9:0]    req_x,
  output logic [9:0]    req_y,
  input  logic [CW-1:0] r_in,
  input  logic [CW-1:0] g_in,
  input  logic [CW-1:0] b_in,
  output logic          frame_start,
  output logic          line_start,
  output logic          hsync,
  output logic          vsync,
  output logic          sync_b,
  output logic          blank_b,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b
);

  localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(HTOT - 1);
  localparam logic [9:0] V_LAST   = 10'(VTOT - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_ON    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] BAR_LAST = 10'(H_ACTIVE / 8 - 1);
  localparam logic       HS_LVL   = (HS_POL != 0);
  localparam logic       VS_LVL   = (VS_POL != 0);

  logic [9:0] hcnt, vcnt, bar_cnt;
  logic [2:0] bar_idx;
  logic       mode, sel, act, hs_i, vs_i;
  // Pipeline word: {pattern select, active, hsync, vsync, bar index}
  logic [6:0] req_word, dly_word;
  logic       sel_d, act_d, hs_d, vs_d;
  logic [2:0] idx_d;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      hcnt    <= '0;
      vcnt    <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
      mode    <= 1'b0;
    end else begin
      if (frame_start) mode <= pattern_en;
      if (hcnt == H_LAST) begin
        hcnt    <= '0;
        bar_cnt <= '0;
        bar_idx <= '0;
        vcnt    <= (vcnt == V_LAST) ? '0 : vcnt + 10'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
        if (hcnt < H_ACT) begin
          if (bar_cnt == BAR_LAST) begin
            bar_cnt <= '0;
            bar_idx <= bar_idx + 3'd1;
          end else begin
            bar_cnt <= bar_cnt + 10'd1;
          end
        end
      end
    end
  end

  assign act         = ~reset & (hcnt < H_ACT) & (vcnt < V_ACT);
  assign hs_i        = (hcnt >= HS_ON) & (hcnt < HS_OFF);
  assign vs_i        = (vcnt >= VS_ON) & (vcnt < VS_OFF);
  assign req_valid   = act;
  assign req_x       = hcnt;
  assign req_y       = vcnt;
  assign line_start  = ~reset & (hcnt == '0);
  assign frame_start = line_start & (vcnt == '0);
  // The select travels with the pixel, so pixel (0,0) already uses the newly sampled mode.
  assign sel         = frame_start ? pattern_en : mode;
  assign req_word    = {sel, act, hs_i, vs_i, bar_idx};

  generate
    if (LAT == 0) begin : g_bypass
      assign dly_word = req_word;
    end else begin : g_pipe
      logic [6:0] stage [LAT];
      always_ff @(posedge vgaclk) begin
        if (reset) begin
          for (int i = 0; i < LAT; i++) stage[i] <= '0;
        end else begin
          stage[0] <= req_word;
          for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
        end
      end
      assign dly_word = stage[LAT-1];
    end
  endgenerate

  assign {sel_d, act_d, hs_d, vs_d, idx_d} = dly_word;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      hsync   <= ~HS_LVL;
      vsync   <= ~VS_LVL;
      sync_b  <= 1'b1;
      blank_b <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else begin
      hsync   <= hs_d ? HS_LVL : ~HS_LVL;
      vsync   <= vs_d ? VS_LVL : ~VS_LVL;
      sync_b  <= ~(hs_d | vs_d);
      blank_b <= act_d;
      if (!act_d) begin
        r <= '0;
        g <= '0;
        b <= '0;
      end else if (sel_d) begin
        r <= {CW{idx_d[2]}};
        g <= {CW{idx_d[1]}};
        b <= {CW{idx_d[0]}};
      end else begin
        r <= r_in;
        g <= g_in;
        b <= b_in;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: two configurations (640-wide/LAT=2/active-low and
// tiny/LAT=0/active-high) checked every cycle against a position-arithmetic model.
module tb_vga_timing_pipe;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, hpol, vpol, lat, cw;
  } cfg_t;

  localparam int NCYC = 60000;

  logic clk = 1'b0;
  logic reset, pattern_en;

  logic       reqv_a, fs_a, ls_a, hs_a, vs_a, syncb_a, blankb_a;
  logic [9:0] reqx_a, reqy_a;
  logic [7:0] ra_in, ga_in, ba_in, ra, ga, ba;

  logic       reqv_b, fs_b, ls_b, hs_b, vs_b, syncb_b, blankb_b;
  logic [9:0] reqx_b, reqy_b;
  logic [3:0] rb_in, gb_in, bb_in, rb, gb, bb;

  cfg_t        cfg [2];
  logic        rst_h  [16];
  int          cnt_h  [16];
  logic        mode_h [2][16];
  logic [23:0] data_h [2][16];
  logic        mode   [2];

  int checks = 0, failures = 0, cyc = -1;
  int cnt = 0, n_up, x_up, y_up;
  logic rst_c, pat;
  logic [5:0] ri;
  logic [31:0] rnd;
  int last_rst = -1, last_ls_a = -1, last_fs_a = -1, last_ls_b = -1, last_fs_b = -1;
  int hlo_a = -1, vlo_a = -1, hhi_b = -1;
  logic prev_hs_a = 1'b1, prev_vs_a = 1'b1, prev_hs_b = 1'b0;

  always #5 clk = ~clk;

  vga_timing_pipe #(
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .LAT(2), .CW(8)
  ) dut_a (
    .vgaclk(clk), .reset(reset), .pattern_en(pattern_en),
    .req_valid(reqv_a), .req_x(reqx_a), .req_y(reqy_a),
    .r_in(ra_in), .g_in(ga_in), .b_in(ba_in),
    .frame_start(fs_a), .line_start(ls_a), .hsync(hs_a), .vsync(vs_a),
    .sync_b(syncb_a), .blank_b(blankb_a), .r(ra), .g(ga), .b(ba)
  );

  vga_timing_pipe #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .LAT(0), .CW(4)
  ) dut_b (
    .vgaclk(clk), .reset(reset), .pattern_en(pattern_en),
    .req_valid(reqv_b), .req_x(reqx_b), .req_y(reqy_b),
    .r_in(rb_in), .g_in(gb_in), .b_in(bb_in),
    .frame_start(fs_b), .line_start(ls_b), .hsync(hs_b), .vsync(vs_b),
    .sync_b(syncb_b), .blank_b(blankb_b), .r(rb), .g(gb), .b(bb)
  );

  function automatic int htot(cfg_t c);
    return c.ha + c.hfp + c.hsw + c.hbp;
  endfunction

  function automatic int vtot(cfg_t c);
    return c.va + c.vfp + c.vsw + c.vbp;
  endfunction

  // {active, hsync region, vsync region, bar index} for the n-th clock of a frame sequence
  function automatic logic [5:0] req_info(cfg_t c, int n);
    int x, y;
    logic [5:0] v;
    x = n % htot(c);
    y = (n / htot(c)) % vtot(c);
    v[5] = (x < c.ha) && (y < c.va);
    v[4] = (x >= c.ha + c.hfp) && (x < c.ha + c.hfp + c.hsw);
    v[3] = (y >= c.va + c.vfp) && (y < c.va + c.vfp + c.vsw);
    v[2:0] = v[5] ? 3'(x / (c.ha / 8)) : 3'd0;
    return v;
  endfunction

  function automatic logic [22:0] exp_req(int d, int c);
    cfg_t k = cfg[d];
    int n, x, y;
    logic on;
    logic [5:0] v;
    n = cnt_h[c & 15];
    on = !rst_h[c & 15];
    x = n % htot(k);
    y = (n / htot(k)) % vtot(k);
    v = req_info(k, n);
    return {v[5] & on, 10'(x), 10'(y), on && x == 0 && y == 0, on && x == 0};
  endfunction

  // Output at cycle k reflects the request made LAT+1 cycles earlier, unless a
  // reset edge fell anywhere in between.
  function automatic logic [27:0] exp_out(int d, int k);
    cfg_t c = cfg[d];
    logic [5:0] v;
    logic [23:0] col;
    logic [7:0] full;
    logic hl, vl;
    int q;
    hl = (c.hpol != 0);
    vl = (c.vpol != 0);
    q = k - c.lat - 1;
    for (int j = q; j < k; j++)
      if (rst_h[j & 15]) return {!hl, !vl, 1'b1, 1'b0, 24'h0};
    v = req_info(c, cnt_h[q & 15]);
    full = 8'((1 << c.cw) - 1);
    if (!v[5]) col = 24'h0;
    else if (mode_h[d][q & 15])
      col = {v[2] ? full : 8'h0, v[1] ? full : 8'h0, v[0] ? full : 8'h0};
    else col = data_h[d][(k - 1) & 15];
    return {v[4] ? hl : !hl, v[3] ? vl : !vl, !(v[4] | v[3]), v[5], col};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  initial begin
    cfg[0] = '{640, 16, 96, 48, 20, 2, 2, 3, 0, 0, 2, 8};
    cfg[1] = '{16, 2, 3, 2, 6, 1, 2, 1, 1, 1, 0, 4};
    for (int i = 0; i < 16; i++) begin
      rst_h[i] = 1'b1;
      cnt_h[i] = 0;
      for (int d = 0; d < 2; d++) begin
        mode_h[d][i] = 1'b0;
        data_h[d][i] = 24'h0;
      end
    end
    mode[0] = 1'b0;
    mode[1] = 1'b0;
    pat = 1'b1;
    reset = 1'b1;
    pattern_en = pat;
    {ra_in, ga_in, ba_in} = 24'h0;
    {rb_in, gb_in, bb_in} = 12'h0;

    ri = req_info(cfg[0], 655);      chk("pin_a_655", ri, 6'b000000);
    ri = req_info(cfg[0], 656);      chk("pin_a_656", ri, 6'b010000);
    ri = req_info(cfg[0], 751);      chk("pin_a_751", ri, 6'b010000);
    ri = req_info(cfg[0], 752);      chk("pin_a_752", ri, 6'b000000);
    ri = req_info(cfg[0], 80);       chk("pin_a_bar1", ri, 6'b100001);
    ri = req_info(cfg[0], 639);      chk("pin_a_bar7", ri, 6'b100111);
    ri = req_info(cfg[0], 22 * 800); chk("pin_a_vs_on", ri, 6'b001000);
    ri = req_info(cfg[0], 24 * 800); chk("pin_a_vs_off", ri, 6'b000000);
    ri = req_info(cfg[0], 21600);    chk("pin_a_wrap", ri, 6'b100000);
    ri = req_info(cfg[1], 18);       chk("pin_b_hs_on", ri, 6'b010000);
    ri = req_info(cfg[1], 21);       chk("pin_b_hs_off", ri, 6'b000000);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      cyc = c;
      cnt = rst_h[(c - 1) & 15] ? 0 : cnt + 1;
      cnt_h[c & 15] = cnt;
      #1;
      rst_c = (c < 3) || (c >= 30000 && c < 30002) ||
              (c > 100 && $urandom_range(14999) == 0);
      if (c == 9000 || (c > 100 && $urandom_range(2999) == 0)) pat = !pat;
      reset = rst_c;
      pattern_en = pat;
      rst_h[c & 15] = rst_c;
      for (int d = 0; d < 2; d++) begin
        if (!rst_c && cnt % (htot(cfg[d]) * vtot(cfg[d])) == 0) mode[d] = pat;
        mode_h[d][c & 15] = mode[d];
      end
      // Upstream A echoes the position requested LAT cycles ago; upstream B is random.
      n_up = cnt_h[(c - cfg[0].lat) & 15];
      x_up = n_up % htot(cfg[0]);
      y_up = (n_up / htot(cfg[0])) % vtot(cfg[0]);
      data_h[0][c & 15] = {8'(x_up), 8'(y_up), 8'hA5};
      {ra_in, ga_in, ba_in} = data_h[0][c & 15];
      rnd = $urandom;
      data_h[1][c & 15] = {4'h0, rnd[11:8], 4'h0, rnd[7:4], 4'h0, rnd[3:0]};
      {rb_in, gb_in, bb_in} = rnd[11:0];
      #1;

      chk("a_req", {reqv_a, reqx_a, reqy_a, fs_a, ls_a}, exp_req(0, c));
      chk("a_out", {hs_a, vs_a, syncb_a, blankb_a, ra, ga, ba}, exp_out(0, c));
      chk("b_req", {reqv_b, reqx_b, reqy_b, fs_b, ls_b}, exp_req(1, c));
      chk("b_out", {hs_b, vs_b, syncb_b, blankb_b, 4'h0, rb, 4'h0, gb, 4'h0, bb}, exp_out(1, c));

      if (c == 3) chk("a_first_req", {reqx_a, reqy_a, reqv_a, fs_a, ls_a}, {20'd0, 3'b111});
      if (c == 5) chk("a_blank_early", blankb_a, 1'b0);
      if (c == 6) chk("a_blank_rise", blankb_a, 1'b1);
      if (c == 86) chk("a_bar1", {ra, ga, ba}, 24'h0000FF);
      if (c == 606) chk("a_bar7", {ra, ga, ba}, 24'hFFFFFF);
      if (c == 14) chk("b_bar5", {rb, gb, bb}, 12'hF0F);
      if (c == 21) chk("b_hs_before", {hs_b, syncb_b}, 2'b01);
      if (c == 22) chk("b_hs_active", {hs_b, syncb_b}, 2'b10);

      if (rst_c) last_rst = c;
      if (ls_a) begin
        if (last_ls_a > last_rst) chk("a_line_period", c - last_ls_a, 800);
        last_ls_a = c;
      end
      if (fs_a) begin
        if (last_fs_a > last_rst) chk("a_frame_period", c - last_fs_a, 21600);
        last_fs_a = c;
      end
      if (ls_b) begin
        if (last_ls_b > last_rst) chk("b_line_period", c - last_ls_b, 23);
        last_ls_b = c;
      end
      if (fs_b) begin
        if (last_fs_b > last_rst) chk("b_frame_period", c - last_fs_b, 230);
        last_fs_b = c;
      end
      if (prev_hs_a && !hs_a) hlo_a = c;
      if (!prev_hs_a && hs_a && hlo_a > last_rst + 1) chk("a_hsync_width", c - hlo_a, 96);
      if (prev_vs_a && !vs_a) vlo_a = c;
      if (!prev_vs_a && vs_a && vlo_a > last_rst + 1) chk("a_vsync_width", c - vlo_a, 1600);
      if (!prev_hs_b && hs_b) hhi_b = c;
      if (prev_hs_b && !hs_b && hhi_b > last_rst + 1) chk("b_hsync_width", c - hhi_b, 3);
      prev_hs_a = hs_a;
      prev_vs_a = vs_a;
      prev_hs_b = hs_b;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
